// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared word width, FSM state encoding and grant
// encoding for the memory-port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned WORD_SIZE = 16;
   localparam int unsigned CNT_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side handshake bundle.
//   fetch side : i_req, i_addr -> i_ack
//   data side  : d_req, d_we, d_addr, d_wdata -> d_ack
//   shared     : rdata, err, busy (arbiter outputs)
// master = requesters (CPU control/datapath), slave = arbiter.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
();
   logic                 i_req;
   logic [WORD_SIZE-1:0] i_addr;
   logic                 i_ack;
   logic                 d_req;
   logic                 d_we;
   logic [WORD_SIZE-1:0] d_addr;
   logic [WORD_SIZE-1:0] d_wdata;
   logic                 d_ack;
   logic [WORD_SIZE-1:0] rdata;
   logic                 err;
   logic                 busy;

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      input  i_ack, d_ack, rdata, err, busy
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      output i_ack, d_ack, rdata, err, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the CPU's single memory port between the
// instruction-fetch and data load/store requesters.
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   req_if        requester handshake (slave modport)
//   readM/writeM  memory strobes, address memory address
//   data          bidirectional memory bus, driven only during a store
//   inputReady    memory completion (read data valid / write accepted)
// Parameters: TIMEOUT (1..255) cycles to wait for inputReady,
//   ARB_MODE 0 = data side has fixed priority, 1 = round-robin.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 8,
   parameter int unsigned ARB_MODE = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   mem_port_arbiter_if.slave    req_if,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   input  logic                 inputReady
);

   state_e               state;
   grant_e               last_grant;
   grant_e               gnt;
   grant_e               pick_c;
   logic [WORD_SIZE-1:0] wdata_q;
   logic [CNT_W-1:0]     cnt;

   // Winner selection; a tie in round-robin mode goes opposite last_grant.
   always_comb begin
      pick_c = req_if.d_req ? GNT_D : GNT_I;
      if (ARB_MODE == 1 && req_if.d_req && req_if.i_req)
         pick_c = (last_grant == GNT_I) ? GNT_D : GNT_I;
   end

   // Store data goes on the bus only while the write strobe is up.
   assign data = writeM ? wdata_q : {WORD_SIZE{1'bz}};

   // Access sequencer: IDLE -> RD/WR -> RESP -> IDLE.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         last_grant   <= GNT_I;
         gnt          <= GNT_I;
         wdata_q      <= '0;
         cnt          <= '0;
         readM        <= 1'b0;
         writeM       <= 1'b0;
         address      <= '0;
         req_if.i_ack <= 1'b0;
         req_if.d_ack <= 1'b0;
         req_if.rdata <= '0;
         req_if.err   <= 1'b0;
         req_if.busy  <= 1'b0;
      end else begin
         req_if.i_ack <= 1'b0;
         req_if.d_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_if.i_req || req_if.d_req) begin
                  gnt         <= pick_c;
                  last_grant  <= pick_c;
                  address     <= (pick_c == GNT_D) ? req_if.d_addr : req_if.i_addr;
                  wdata_q     <= req_if.d_wdata;
                  cnt         <= '0;
                  req_if.busy <= 1'b1;
                  if (pick_c == GNT_D && req_if.d_we) begin
                     state  <= ST_WR;
                     writeM <= 1'b1;
                  end else begin
                     state <= ST_RD;
                     readM <= 1'b1;
                  end
               end
            end
            ST_RD, ST_WR: begin
               cnt <= cnt + CNT_W'(1);
               // Completion wins over a timeout landing on the same edge.
               if (inputReady || cnt == CNT_W'(TIMEOUT)) begin
                  state        <= ST_RESP;
                  readM        <= 1'b0;
                  writeM       <= 1'b0;
                  req_if.i_ack <= (gnt == GNT_I);
                  req_if.d_ack <= (gnt == GNT_D);
                  req_if.err   <= ~inputReady;
                  if (!inputReady)
                     req_if.rdata <= '0;
                  else if (state == ST_RD)
                     req_if.rdata <= data;
               end
            end
            ST_RESP: begin
               state       <= ST_IDLE;
               req_if.err  <= 1'b0;
               req_if.busy <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter.
// dut0 (fixed priority) sits on a small memory model with a pulled-up data
// bus; dut1 (round-robin) answers every access at once with its address.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   typedef struct {
      bit          is_d;
      logic [15:0] rdata;
      bit          err;
      bit          chk_rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ready_en = 1'b1;
   int          n_checks = 0;
   int          n_pass = 0;
   exp_t        sb0[$];
   exp_t        sb1[$];

   mem_port_arbiter_if if0 ();
   mem_port_arbiter_if if1 ();

   logic        readM0, writeM0, ready0;
   logic [15:0] address0;
   wire  [15:0] data0;
   logic        readM1, writeM1, ready1;
   logic [15:0] address1;
   wire  [15:0] data1;
   logic [15:0] mem [256];

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(8), .ARB_MODE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .req_if(if0.slave), .readM(readM0),
      .writeM(writeM0), .address(address0), .data(data0), .inputReady(ready0));

   mem_port_arbiter #(.TIMEOUT(8), .ARB_MODE(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .req_if(if1.slave), .readM(readM1),
      .writeM(writeM1), .address(address1), .data(data1), .inputReady(ready1));

   for (genvar g = 0; g < 16; g++) begin : g_pu
      pullup (data0[g]);
   end

   function automatic logic [15:0] init_word(input logic [7:0] a);
      return (a == 8'h10) ? 16'h6000 : {a, ~a};
   endfunction

   assign ready0 = ready_en & (readM0 | writeM0);
   assign data0  = (readM0 && ready_en) ? mem[address0[7:0]] : 16'hzzzz;
   assign ready1 = readM1 | writeM1;
   assign data1  = readM1 ? address1 : 16'hzzzz;

   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
      end else if (writeM0 && ready0) begin
         mem[address0[7:0]] <= data0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Scoreboard for dut0 plus per-cycle bus invariants.
   always @(negedge clk) begin : mon0
      exp_t e;
      if (if0.i_ack || if0.d_ack) begin
         if (sb0.size() == 0) begin
            check("sb0_unexpected_ack", {30'd0, if0.d_ack, if0.i_ack}, 32'd0);
         end else begin
            e = sb0.pop_front();
            check("sb0_side", {30'd0, if0.d_ack, if0.i_ack}, e.is_d ? 32'd2 : 32'd1);
            check("sb0_err", 32'(if0.err), 32'(e.err));
            if (e.chk_rd) check("sb0_rdata", 32'(if0.rdata), 32'(e.rdata));
         end
      end
      check("rw_exclusive", 32'(readM0 & writeM0), 32'd0);
      if (!writeM0 && !(readM0 && ready_en)) check("data_z", 32'(data0), 32'h0000ffff);
   end

   // Scoreboard for dut1 (round-robin order).
   always @(negedge clk) begin : mon1
      exp_t e;
      if (if1.i_ack || if1.d_ack) begin
         if (sb1.size() == 0) begin
            check("sb1_unexpected_ack", {30'd0, if1.d_ack, if1.i_ack}, 32'd0);
         end else begin
            e = sb1.pop_front();
            check("sb1_side", {30'd0, if1.d_ack, if1.i_ack}, e.is_d ? 32'd2 : 32'd1);
            check("sb1_rdata", 32'(if1.rdata), 32'(e.rdata));
         end
      end
   end

   // One access on dut0: checks strobe, address, bus data, latency and idle gap.
   task automatic access(input string tag, input bit is_d, input bit we,
                         input logic [15:0] addr, input logic [15:0] wd, input int exp_lat);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      if (is_d) begin
         if0.d_we = we; if0.d_addr = addr; if0.d_wdata = wd; if0.d_req = 1'b1;
      end else begin
         if0.i_addr = addr; if0.i_req = 1'b1;
      end
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check({tag, "_strobe"}, {30'd0, readM0, writeM0}, (is_d && we) ? 32'd1 : 32'd2);
            check({tag, "_addr"}, 32'(address0), 32'(addr));
            if (is_d && we) check({tag, "_wdata"}, 32'(data0), 32'(wd));
         end
         seen = if0.i_ack | if0.d_ack;
      end
      check({tag, "_lat"}, 32'(n), 32'(exp_lat));
      check({tag, "_strobe_off"}, {30'd0, readM0, writeM0}, 32'd0);
      if0.i_req = 1'b0;
      if0.d_req = 1'b0;
      @(negedge clk);
      check({tag, "_idle"}, {29'd0, if0.busy, if0.i_ack, if0.d_ack}, 32'd0);
   endtask

   initial begin : stim
      int n;
      int acks;
      if0.i_req = 1'b0; if0.i_addr = '0; if0.d_req = 1'b0; if0.d_we = 1'b0;
      if0.d_addr = '0; if0.d_wdata = '0;
      if1.i_req = 1'b0; if1.i_addr = '0; if1.d_req = 1'b0; if1.d_we = 1'b0;
      if1.d_addr = '0; if1.d_wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_strobes", {30'd0, readM0, writeM0}, 32'd0);
      check("rst_flags", {28'd0, if0.i_ack, if0.d_ack, if0.err, if0.busy}, 32'd0);
      check("rst_address", 32'(address0), 32'd0);
      check("rst_rdata", 32'(if0.rdata), 32'd0);
      check("rst_dut1_busy", 32'(if1.busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single fetch
      sb0.push_back('{is_d: 1'b0, rdata: 16'h6000, err: 1'b0, chk_rd: 1'b1});
      access("fetch", 1'b0, 1'b0, 16'h0010, 16'h0000, 2);

      // Store then load of the same word
      sb0.push_back('{is_d: 1'b1, rdata: 16'h0000, err: 1'b0, chk_rd: 1'b0});
      access("store", 1'b1, 1'b1, 16'h0040, 16'hBEEF, 2);
      sb0.push_back('{is_d: 1'b1, rdata: 16'hBEEF, err: 1'b0, chk_rd: 1'b1});
      access("load", 1'b1, 1'b0, 16'h0040, 16'h0000, 2);

      // Tie under fixed priority: D then I, three cycles apart
      sb0.push_back('{is_d: 1'b1, rdata: init_word(8'h30), err: 1'b0, chk_rd: 1'b1});
      sb0.push_back('{is_d: 1'b0, rdata: init_word(8'h20), err: 1'b0, chk_rd: 1'b1});
      if0.i_addr = 16'h0020; if0.i_req = 1'b1;
      if0.d_addr = 16'h0030; if0.d_we = 1'b0; if0.d_req = 1'b1;
      n = 0;
      while (!(if0.i_ack || if0.d_ack) && n < 40) begin @(negedge clk); n++; end
      check("tie_first_lat", 32'(n), 32'd2);
      check("tie_first_is_d", 32'(if0.d_ack), 32'd1);
      if0.d_req = 1'b0;
      @(negedge clk); n++;
      while (!(if0.i_ack || if0.d_ack) && n < 40) begin @(negedge clk); n++; end
      check("tie_second_lat", 32'(n), 32'd5);
      check("tie_second_is_i", 32'(if0.i_ack), 32'd1);
      if0.i_req = 1'b0;
      @(negedge clk);

      // Timeout: ack+err nine cycles after readM rose
      ready_en = 1'b0;
      sb0.push_back('{is_d: 1'b0, rdata: 16'h0000, err: 1'b1, chk_rd: 1'b1});
      access("timeout", 1'b0, 1'b0, 16'h0050, 16'h0000, 10);
      ready_en = 1'b1;

      // Reset during RD aborts without an ack
      if0.i_addr = 16'h0060; if0.i_req = 1'b1;
      @(negedge clk);
      check("abort_readM_before", 32'(readM0), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check("abort_readM_after", 32'(readM0), 32'd0);
      check("abort_busy_after", 32'(if0.busy), 32'd0);
      if0.i_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("abort_no_ack", {30'd0, if0.i_ack, if0.d_ack}, 32'd0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      sb0.push_back('{is_d: 1'b0, rdata: init_word(8'h60), err: 1'b0, chk_rd: 1'b1});
      access("after_abort", 1'b0, 1'b0, 16'h0060, 16'h0000, 2);

      // Stuck request: held i_req yields a second fetch
      sb0.push_back('{is_d: 1'b0, rdata: init_word(8'h70), err: 1'b0, chk_rd: 1'b1});
      sb0.push_back('{is_d: 1'b0, rdata: init_word(8'h70), err: 1'b0, chk_rd: 1'b1});
      if0.i_addr = 16'h0070; if0.i_req = 1'b1;
      n = 0; acks = 0;
      while (acks < 2 && n < 40) begin
         @(negedge clk); n++;
         if (if0.i_ack) acks++;
      end
      check("stuck_ack_count", 32'(acks), 32'd2);
      check("stuck_second_lat", 32'(n), 32'd5);
      if0.i_req = 1'b0;
      repeat (2) @(negedge clk);

      // Round-robin on dut1: persistent tie alternates D, I, D, I
      sb1.push_back('{is_d: 1'b1, rdata: 16'h000B, err: 1'b0, chk_rd: 1'b1});
      sb1.push_back('{is_d: 1'b0, rdata: 16'h000A, err: 1'b0, chk_rd: 1'b1});
      sb1.push_back('{is_d: 1'b1, rdata: 16'h000B, err: 1'b0, chk_rd: 1'b1});
      sb1.push_back('{is_d: 1'b0, rdata: 16'h000A, err: 1'b0, chk_rd: 1'b1});
      if1.i_addr = 16'h000A; if1.d_addr = 16'h000B; if1.d_we = 1'b0;
      if1.i_req = 1'b1; if1.d_req = 1'b1;
      n = 0; acks = 0;
      while (acks < 4 && n < 60) begin
         @(negedge clk); n++;
         if (if1.i_ack || if1.d_ack) acks++;
      end
      check("rr_ack_count", 32'(acks), 32'd4);
      check("rr_fourth_lat", 32'(n), 32'd11);
      if1.i_req = 1'b0; if1.d_req = 1'b0;
      repeat (4) @(negedge clk);

      check("sb0_drained", 32'(sb0.size()), 32'd0);
      check("sb1_drained", 32'(sb1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
